// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, opcodes,
// immediate/result selectors and instruction classes.
package cu_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  localparam logic [6:0] OP_IMM = 7'd19;
  localparam logic [6:0] OP     = 7'd51;
  localparam logic [6:0] LOAD   = 7'd3;
  localparam logic [6:0] STORE  = 7'd35;
  localparam logic [6:0] BRANCH = 7'd99;
  localparam logic [6:0] JAL    = 7'd111;
  localparam logic [6:0] LUI    = 7'd55;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // Instruction class produced by the decoder
  localparam logic [2:0] FMT_NONE   = 3'd0;
  localparam logic [2:0] FMT_OP_IMM = 3'd1;
  localparam logic [2:0] FMT_OP     = 3'd2;
  localparam logic [2:0] FMT_LOAD   = 3'd3;
  localparam logic [2:0] FMT_STORE  = 3'd4;
  localparam logic [2:0] FMT_BRANCH = 3'd5;
  localparam logic [2:0] FMT_JAL    = 3'd6;
  localparam logic [2:0] FMT_LUI    = 3'd7;

endpackage

// File: rtl/multicycle_controlunit_decoder.sv
// Combinational instruction decoder: maps the IR contents to instruction class,
// ALU/immediate/result selects and legality.
module cu_decoder
  import cu_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [2:0]  fmt,
  output logic [3:0]  aluctrl,
  output logic        alusrc,
  output logic [2:0]  immsrc,
  output logic [1:0]  result_src,
  output logic        writes_rd,
  output logic        is_mem,
  output logic        is_store,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       unused_fields;

  assign opcode        = instruction[6:0];
  assign funct3        = instruction[14:12];
  assign funct7_b5     = instruction[30];
  assign unused_fields = ^{instruction[31], instruction[29:15], instruction[11:7]};

  always_comb begin
    fmt        = FMT_NONE;
    aluctrl    = ALU_ADD;
    alusrc     = 1'b0;
    immsrc     = IMM_I;
    result_src = RES_ALU;
    writes_rd  = 1'b0;
    is_mem     = 1'b0;
    is_store   = 1'b0;
    legal      = 1'b0;
    case (opcode)
      OP_IMM: begin
        fmt       = FMT_OP_IMM;
        // Only srai uses funct7[5]; for other I-type ops that bit is immediate data
        aluctrl   = {(funct3 == 3'b101) & funct7_b5, funct3};
        alusrc    = 1'b1;
        writes_rd = 1'b1;
        legal     = 1'b1;
      end
      OP: begin
        fmt       = FMT_OP;
        aluctrl   = {funct7_b5, funct3};
        writes_rd = 1'b1;
        legal     = 1'b1;
      end
      LOAD: begin
        fmt        = FMT_LOAD;
        alusrc     = 1'b1;
        result_src = RES_MEM;
        writes_rd  = 1'b1;
        is_mem     = 1'b1;
        legal      = 1'b1;
      end
      STORE: begin
        fmt      = FMT_STORE;
        alusrc   = 1'b1;
        immsrc   = IMM_S;
        is_mem   = 1'b1;
        is_store = 1'b1;
        legal    = 1'b1;
      end
      BRANCH: begin
        fmt     = FMT_BRANCH;
        aluctrl = ALU_SUB;
        immsrc  = IMM_B;
        legal   = (funct3[2:1] == 2'b00);
      end
      JAL: begin
        fmt        = FMT_JAL;
        alusrc     = 1'b1;
        immsrc     = IMM_J;
        result_src = RES_PC4;
        writes_rd  = 1'b1;
        legal      = 1'b1;
      end
      LUI: begin
        fmt        = FMT_LUI;
        alusrc     = 1'b1;
        immsrc     = IMM_U;
        result_src = RES_IMM;
        writes_rd  = 1'b1;
        legal      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controlunit.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// memory port, with a wait-counter timeout and sticky trap flags.
module multicycle_controlunit
  import cu_pkg::*;
#(
  parameter int unsigned ALU_W       = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  localparam int unsigned TO_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             eq,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pcsrc,
  output logic             regwrite,
  output logic [1:0]       result_src,
  output logic [ALU_W-1:0] aluctrl,
  output logic             alusrc,
  output logic [2:0]       immsrc,
  output logic             illegal,
  output logic             bus_err
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            br_taken_q, br_taken_d;
  logic            illegal_q, illegal_d;
  logic            bus_err_q, bus_err_d;

  logic [2:0] dec_fmt;
  logic [3:0] dec_aluctrl;
  logic       dec_alusrc;
  logic [2:0] dec_immsrc;
  logic [1:0] dec_result_src;
  logic       dec_writes_rd;
  logic       dec_is_mem;
  logic       dec_is_store;
  logic       dec_legal;

  cu_decoder u_decoder (
    .instruction (instruction),
    .fmt         (dec_fmt),
    .aluctrl     (dec_aluctrl),
    .alusrc      (dec_alusrc),
    .immsrc      (dec_immsrc),
    .result_src  (dec_result_src),
    .writes_rd   (dec_writes_rd),
    .is_mem      (dec_is_mem),
    .is_store    (dec_is_store),
    .legal       (dec_legal)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    br_taken_d = br_taken_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pcsrc      = 1'b0;
    regwrite   = 1'b0;
    result_src = RES_ALU;
    aluctrl    = '0;
    alusrc     = 1'b0;
    immsrc     = IMM_I;
    illegal    = illegal_q;
    bus_err    = bus_err_q;

    // ALU/imm selects stay valid through MEM and WB: the address, branch target
    // and U/J immediates are formed from them in those states.
    if (state_q inside {EXEC, MEM, WB}) begin
      aluctrl = ALU_W'(dec_aluctrl);
      alusrc  = dec_alusrc;
      immsrc  = dec_immsrc;
    end

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (cnt_q == TO_LIMIT) begin
          bus_err_d = 1'b1;
          state_d   = TRAP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      DECODE: begin
        if (dec_legal) begin
          state_d = EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = TRAP;
        end
      end
      EXEC: begin
        if (dec_fmt == FMT_BRANCH) begin
          br_taken_d = (instruction[14:12] == 3'b000) ? eq : !eq;
        end
        state_d = dec_is_mem ? MEM : WB;
      end
      MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = dec_is_store;
        if (mem_ready) begin
          state_d = WB;
        end else if (cnt_q == TO_LIMIT) begin
          bus_err_d = 1'b1;
          state_d   = TRAP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      WB: begin
        pc_we      = 1'b1;
        pcsrc      = (dec_fmt == FMT_JAL) | ((dec_fmt == FMT_BRANCH) & br_taken_q);
        regwrite   = dec_writes_rd;
        result_src = dec_result_src;
        state_d    = FETCH;
      end
      TRAP: ;
      default: state_d = FETCH;
    endcase

    // Outputs are forced quiet for the whole reset cycle, not just after it.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pcsrc      = 1'b0;
      regwrite   = 1'b0;
      result_src = '0;
      aluctrl    = '0;
      alusrc     = 1'b0;
      immsrc     = '0;
      illegal    = 1'b0;
      bus_err    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      cnt_q      <= '0;
      br_taken_q <= 1'b0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      br_taken_q <= br_taken_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

endmodule
